i2s_tx: RTL and testbench

- Serialises stereo 32-bit signed samples to the audio codec DAC in I2S format.
- Acts as bus master: generates BCLK, LRCK and DACDAT from CLOCK_50.
- Sits at the output end of the DSP chain and supplies the per-frame `tick` strobe that paces every upstream processing block.
- Pulls one stereo sample per frame from the chain's held outputs (out_L/out_R of the last stage).

---
 rtl/audio_pkg.sv | 24 ++
 rtl/i2s_bclk_gen.sv | 51 +++++
 rtl/i2s_tx.sv | 65 ++++++
 tb/tb_i2s_tx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio types and frame-rate constants for the DSP chain and the I2S output stage.
// Combinational definitions only; no latency, no flow control.
package audio_pkg;

   localparam int SAMPLE_W      = 32;
   localparam int BCLK_HALF_DEF = 8;
   localparam int CLK_HZ        = 50_000_000;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef struct packed {
      sample_t l;
      sample_t r;
   } stereo_t;

   // CLOCK_50 cycles per stereo frame; DSP blocks size their delay lines from this
   function automatic int frame_cycles(input int bclk_half, input int dw);
      return 4 * dw * bclk_half;
   endfunction

   localparam int FRAME_CYCLES = frame_cycles(BCLK_HALF_DEF, SAMPLE_W);
   localparam int FRAME_HZ     = CLK_HZ / FRAME_CYCLES;

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S timing: BCLK divider, fall-event strobe, bit-position counter and LRCK (registered at each BCLK fall).
// Free-running master timing; no backpressure.
module i2s_bclk_gen
   import audio_pkg::*;
#(
   parameter int BCLK_HALF = BCLK_HALF_DEF,
   parameter int DW        = SAMPLE_W,
   parameter int PW        = $clog2(2 * DW)
) (
   input  logic          CLOCK_50,
   input  logic          RESET_N,
   output logic          bclk,
   output logic          lrck,
   output logic          fall,
   output logic [PW-1:0] p_nxt
);

   localparam int            CW       = $clog2(BCLK_HALF);
   localparam logic [CW-1:0] DIV_LAST = CW'(BCLK_HALF - 1);
   localparam logic [PW-1:0] LR_ON    = PW'(DW - 1);
   localparam logic [PW-1:0] LR_OFF   = PW'(2 * DW - 2);

   logic [CW-1:0] div_cnt;
   logic [PW-1:0] p;
   logic          wrap;

   assign wrap  = (div_cnt == DIV_LAST);
   assign fall  = wrap & bclk;
   // 2*DW is a power of two, so the position wraps 63 -> 0 naturally
   assign p_nxt = p + 1'b1;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
         p       <= '1;
         lrck    <= 1'b0;
      end else begin
         div_cnt <= wrap ? '0 : div_cnt + 1'b1;
         if (wrap) begin
            bclk <= ~bclk;
         end
         if (fall) begin
            p    <= p_nxt;
            // one-bit I2S delay: word select leads each MSB by one BCLK
            lrck <= (p_nxt >= LR_ON) && (p_nxt <= LR_OFF);
         end
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// I2S master DAC transmitter: captures in_L/in_R 31 BCLKs after tick, left MSB leaves one BCLK later.
// No backpressure: upstream must hold in_L/in_R stable from one cycle after tick until capture.
module i2s_tx
   import audio_pkg::*;
#(
   parameter int BCLK_HALF = BCLK_HALF_DEF,
   parameter int DW        = SAMPLE_W
) (
   input  logic                 CLOCK_50,
   input  logic                 RESET_N,
   input  logic signed [DW-1:0] in_L,
   input  logic signed [DW-1:0] in_R,
   input  logic                 mute,
   output logic                 tick,
   output logic                 bclk,
   output logic                 lrck,
   output logic                 dacdat
);

   localparam int            PW     = $clog2(2 * DW);
   localparam int            BW     = $clog2(DW);
   localparam logic [PW-1:0] P_TICK = PW'(DW);
   localparam logic [PW-1:0] P_CAP  = PW'(2 * DW - 1);

   logic                 fall;
   logic [PW-1:0]        p_nxt;
   logic [BW-1:0]        bit_idx;
   logic signed [DW-1:0] fr_L;
   logic signed [DW-1:0] fr_R;

   i2s_bclk_gen #(
      .BCLK_HALF (BCLK_HALF),
      .DW        (DW),
      .PW        (PW)
   ) u_bclk_gen (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .bclk     (bclk),
      .lrck     (lrck),
      .fall     (fall),
      .p_nxt    (p_nxt)
   );

   // DW is a power of two: DW-1-p and 2*DW-1-p both reduce to the inverted low bits of p
   assign bit_idx = ~p_nxt[BW-1:0];

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         tick   <= 1'b0;
         dacdat <= 1'b0;
         fr_L   <= '0;
         fr_R   <= '0;
      end else begin
         tick <= fall && (p_nxt == P_TICK);
         if (fall) begin
            dacdat <= p_nxt[BW] ? fr_R[bit_idx] : fr_L[bit_idx];
            if (p_nxt == P_CAP) begin
               fr_L <= mute ? '0 : in_L;
               fr_R <= mute ? '0 : in_R;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: default instance checked against a frame scoreboard, plus a BCLK_HALF=2/DW=16 instance.
// Words are reassembled from dacdat on BCLK rises and compared with the frames queued when driven.
module tb_i2s_tx;
   import audio_pkg::*;

   logic               CLOCK_50;
   logic               RESET_N;
   logic signed [31:0] in_L, in_R;
   logic               mute;
   logic               tick, bclk, lrck, dacdat;
   logic signed [15:0] in_L2, in_R2;
   logic               mute2;
   logic               tick2, bclk2, lrck2, dacdat2;

   int n_pass = 0;
   int n_chk  = 0;
   int cyc;

   stereo_t sb[$];

   int          p_exp = 63, last_fall = -1, last_tick = -1, n_ticks = 0, tk_cyc = 0;
   bit          fall_seen = 0, prev_bclk = 0, prev_tick = 0;
   logic [31:0] sr = '0;

   int          p2 = 31, f2 = 0, last_fall2 = -1, last_tick2 = -1;
   bit          prev_bclk2 = 0;
   logic [15:0] sr2 = '0;

   i2s_tx dut (
      .CLOCK_50 (CLOCK_50), .RESET_N (RESET_N),
      .in_L (in_L), .in_R (in_R), .mute (mute),
      .tick (tick), .bclk (bclk), .lrck (lrck), .dacdat (dacdat)
   );

   i2s_tx #(.BCLK_HALF(2), .DW(16)) dut2 (
      .CLOCK_50 (CLOCK_50), .RESET_N (RESET_N),
      .in_L (in_L2), .in_R (in_R2), .mute (mute2),
      .tick (tick2), .bclk (bclk2), .lrck (lrck2), .dacdat (dacdat2)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Default instance monitor: BCLK timing, LRCK, tick placement and serial words
   always @(negedge CLOCK_50) begin
      if (!RESET_N) begin
         p_exp = 63; fall_seen = 0; last_fall = -1; last_tick = -1;
         prev_bclk = 0; prev_tick = 0; sr = '0;
      end else begin
         if (prev_bclk && !bclk) begin
            p_exp = (p_exp + 1) % 64;
            if (!fall_seen) chk("first_fall_cycle", 64'(cyc), 64'(16));
            else            chk("bclk_period", 64'(cyc - last_fall), 64'(16));
            fall_seen = 1;
            last_fall = cyc;
            chk("lrck", 64'(lrck), 64'(p_exp >= 31 && p_exp <= 62));
         end
         if (!prev_bclk && bclk && fall_seen) begin
            sr = {sr[30:0], dacdat};
            if (p_exp == 31 || p_exp == 63) begin
               if (sb.size() == 0) begin
                  chk("sb_underflow", 64'(sb.size()), 64'(1));
               end else if (p_exp == 31) begin
                  chk("left_word", 64'(sr), 64'($unsigned(sb[0].l)));
               end else begin
                  chk("right_word", 64'(sr), 64'($unsigned(sb[0].r)));
                  void'(sb.pop_front());
               end
            end
         end
         if (tick) begin
            chk("tick_width", 64'(prev_tick), 64'(0));
            chk("tick_vs_fall", 64'(cyc - last_fall), 64'(0));
            chk("tick_p", 64'(p_exp), 64'(32));
            if (last_tick >= 0) chk("tick_spacing", 64'(cyc - last_tick), 64'(1024));
            last_tick = cyc;
            n_ticks++;
         end
         prev_bclk = bclk;
         prev_tick = tick;
      end
   end

   // Narrow instance monitor: constant inputs, so frame 1 is zeros and later frames are 8001/1234
   always @(negedge CLOCK_50) begin
      if (!RESET_N) begin
         p2 = 31; f2 = 0; last_fall2 = -1; last_tick2 = -1; prev_bclk2 = 0; sr2 = '0;
      end else begin
         if (prev_bclk2 && !bclk2) begin
            p2 = (p2 + 1) % 32;
            if (p2 == 0) f2++;
            if (last_fall2 < 0)  chk("first_fall2", 64'(cyc), 64'(4));
            else if (f2 <= 3)    chk("bclk2_period", 64'(cyc - last_fall2), 64'(4));
            if (f2 <= 3) chk("lrck2", 64'(lrck2), 64'(p2 >= 15 && p2 <= 30));
            last_fall2 = cyc;
         end
         if (!prev_bclk2 && bclk2 && f2 >= 1) begin
            sr2 = {sr2[14:0], dacdat2};
            if (f2 <= 3 && p2 == 15) chk("word2_left",  64'(sr2), 64'(f2 == 1 ? 16'h0000 : 16'h8001));
            if (f2 <= 3 && p2 == 31) chk("word2_right", 64'(sr2), 64'(f2 == 1 ? 16'h0000 : 16'h1234));
         end
         if (tick2) begin
            if (last_tick2 >= 0) chk("tick2_spacing", 64'(cyc - last_tick2), 64'(128));
            last_tick2 = cyc;
         end
         prev_bclk2 = bclk2;
      end
   end

   task automatic wait_tick();
      bit seen = 0;
      for (int i = 0; i < 1100 && !seen; i++) begin
         @(negedge CLOCK_50); #1;
         seen = tick;
      end
      chk("wait_tick", 64'(seen), 64'(1));
      tk_cyc = cyc;
   endtask

   task automatic wait_p(input int t);
      bit seen = 0;
      for (int i = 0; i < 1100 && !seen; i++) begin
         @(negedge CLOCK_50); #1;
         seen = (p_exp == t);
      end
      chk("wait_p", 64'(seen), 64'(1));
   endtask

   // Answer one tick with a sample pair and queue what the next frame must carry
   task automatic send(input logic [31:0] l, input logic [31:0] r, input bit mute_now, input bit mute_mid);
      stereo_t e;
      wait_tick();
      @(negedge CLOCK_50); #1;
      in_L = l;
      in_R = r;
      mute = mute_now;
      if (mute_mid) begin
         wait_p(40);
         mute = 1'b1;
      end
      e.l = (mute_now || mute_mid) ? '0 : l;
      e.r = (mute_now || mute_mid) ? '0 : r;
      sb.push_back(e);
   endtask

   initial begin
      int c0, n0;
      RESET_N = 1'b0;
      in_L = '0; in_R = '0; mute = 1'b0;
      in_L2 = 16'sh8001; in_R2 = 16'sh1234; mute2 = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      #1;
      chk("rst_bclk",   64'(bclk),   64'(0));
      chk("rst_lrck",   64'(lrck),   64'(0));
      chk("rst_dacdat", 64'(dacdat), 64'(0));
      chk("rst_tick",   64'(tick),   64'(0));
      chk("rst_bclk2",  64'(bclk2),  64'(0));
      chk("rst_tick2",  64'(tick2),  64'(0));
      RESET_N = 1'b1;
      sb.push_back('0);

      send(32'hA5A50F0F, 32'h80000001, 1'b0, 1'b0);
      send(32'h7FFFFFFF, 32'h12345678, 1'b1, 1'b0);
      send(32'h13572468, 32'hFEDCBA98, 1'b0, 1'b0);
      send(32'h0F0F0F0F, 32'h55AA55AA, 1'b0, 1'b1);
      send(32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);

      c0 = tk_cyc;
      n0 = n_ticks;
      for (int i = 0; i < 10; i++) send($urandom, $urandom, 1'b0, 1'b0);
      chk("ticks_10_frames", 64'(n_ticks - n0), 64'(10));
      chk("span_10_frames",  64'(tk_cyc - c0),  64'(10240));

      send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
      wait_p(20);
      repeat (8) @(negedge CLOCK_50);
      #1;
      chk("pre_rst_bclk",   64'(bclk),   64'(1));
      chk("pre_rst_dacdat", 64'(dacdat), 64'(1));
      RESET_N = 1'b0;
      #1;
      chk("mid_rst_bclk",   64'(bclk),   64'(0));
      chk("mid_rst_lrck",   64'(lrck),   64'(0));
      chk("mid_rst_dacdat", 64'(dacdat), 64'(0));
      chk("mid_rst_tick",   64'(tick),   64'(0));
      sb.delete();
      repeat (3) @(negedge CLOCK_50);
      #1;
      RESET_N = 1'b1;
      sb.push_back('0);

      send(32'h5A5A5A5A, 32'hC3C3C3C3, 1'b0, 1'b0);
      wait_p(0);
      wait_p(63);
      repeat (10) @(negedge CLOCK_50);
      #1;
      chk("sb_drained", 64'(sb.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
